// File: rtl/pkt_rx_buf_pkg.sv
// Shared definitions for the packet receive buffer: write-FSM state
// encoding and the drop-counter width plus its saturating increment.
package pkt_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_e;

  localparam int DROP_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pkt_rx_buf_if.sv
// Stream-in / ready-valid-out bundle for pkt_rx_buf.
// master = stream source plus downstream consumer, slave = the buffer.
interface pkt_rx_buf_if #(
  parameter int DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0] in_data;
  logic                 in_sot;
  logic                 in_eot;
  logic                 in_valid;
  logic [DATAWIDTH-1:0] out_data;
  logic                 out_sot;
  logic                 out_eot;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_sot, in_eot, in_valid, out_ready,
    input  out_data, out_sot, out_eot, out_valid
  );

  modport slave (
    input  in_data, in_sot, in_eot, in_valid, out_ready,
    output out_data, out_sot, out_eot, out_valid
  );
endinterface

// File: rtl/pkt_rx_buf_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enabled read. The read register holds its value while re_i is low, so it
// can double as the output holding register. No reset, so it maps onto
// block RAM.
module ram_dp_1r1w #(
  parameter int WIDTH     = 9,
  parameter int ADDRWIDTH = 5
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDRWIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [ADDRWIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);
  logic [WIDTH-1:0] mem_q [0:(1<<ADDRWIDTH)-1];
  logic [WIDTH-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read, held when not enabled
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/pkt_rx_buf.sv
// Store-and-forward packet receive buffer.
// A sot/eot/valid stream is written into a circular RAM behind a
// speculative write pointer. A packet becomes readable only when its eot
// commits. Packets that overflow the RAM or break framing are rewound and
// never appear on the output side.
// Optional build macro PKT_RX_BUF_DROP_CNT_EN adds a saturating 16-bit
// drop_cnt output that counts overflow events.
module pkt_rx_buf
  import pkt_rx_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 5
) (
  input  logic               clk,
  input  logic               reset,
  pkt_rx_buf_if.slave        bus,
  output logic [ADDRWIDTH:0] pkt_count,
  output logic               overflow,
  output logic               proto_err
`ifdef PKT_RX_BUF_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);
  localparam int PTR_W = ADDRWIDTH + 1;
  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [PTR_W-1:0] FULL_DIFF = PTR_W'(DEPTH);

  wr_state_e        state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] wr_cmt_q, wr_cmt_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] base_ptr;

  logic start_pkt, cont_pkt, want_wr, full_w;
  logic ram_we, ovf_hit, perr_hit, commit;
  logic overflow_q, proto_err_q;

  logic                 out_valid_q, first_q;
  logic [ADDRWIDTH:0]   pkt_count_q;
  logic                 empty, pop, pop_eot, ram_re;
  logic [DATAWIDTH:0]   ram_rdata;

  // Write decode: which incoming word is stored, dropped or flagged
  always_comb begin
    start_pkt = bus.in_valid & bus.in_sot;
    cont_pkt  = bus.in_valid & ~bus.in_sot & (state_q == ST_RECV);
    // A sot always restarts from the last committed boundary, which
    // discards any unfinished packet still in flight.
    base_ptr  = start_pkt ? wr_cmt_q : wr_ptr_q;
    want_wr   = start_pkt | cont_pkt;
    full_w    = (base_ptr - rd_ptr_q) == FULL_DIFF;
    ram_we    = want_wr & ~full_w;
    ovf_hit   = want_wr & full_w;
    commit    = ram_we & bus.in_eot;
    perr_hit  = bus.in_valid & ((state_q == ST_IDLE) ? ~bus.in_sot : bus.in_sot);
  end

  // Next-state for the write FSM and write pointers
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    wr_cmt_d = wr_cmt_q;
    if (ovf_hit) begin
      wr_ptr_d = wr_cmt_q;
      state_d  = bus.in_eot ? ST_IDLE : ST_DISCARD;
    end else if (ram_we) begin
      wr_ptr_d = base_ptr + 1'b1;
      if (bus.in_eot) begin
        wr_cmt_d = base_ptr + 1'b1;
        state_d  = ST_IDLE;
      end else begin
        state_d  = ST_RECV;
      end
    end else if (bus.in_valid && bus.in_eot && state_q == ST_DISCARD) begin
      state_d = ST_IDLE;
    end
  end

  // Write FSM state and pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      wr_cmt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      wr_cmt_q <= wr_cmt_d;
    end
  end

  // Registered one-cycle status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_hit;
      proto_err_q <= perr_hit;
    end
  end

  ram_dp_1r1w #(
    .WIDTH     (DATAWIDTH + 1),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (base_ptr[ADDRWIDTH-1:0]),
    .wdata_i ({bus.in_eot, bus.in_data}),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[ADDRWIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  // Read control: fetch whenever committed data exists and the output slot
  // is free or being emptied this cycle, giving one word per cycle.
  always_comb begin
    empty   = (rd_ptr_q == wr_cmt_q);
    pop     = out_valid_q & bus.out_ready;
    pop_eot = pop & ram_rdata[DATAWIDTH];
    ram_re  = ~empty & (~out_valid_q | bus.out_ready);
  end

  // Read pointer, output valid, start-of-packet tracking, packet counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b1;
      pkt_count_q <= '0;
    end else begin
      if (ram_re) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
      if (pop) first_q <= ram_rdata[DATAWIDTH];
      case ({commit, pop_eot})
        2'b10:   pkt_count_q <= pkt_count_q + 1'b1;
        2'b01:   pkt_count_q <= pkt_count_q - 1'b1;
        default: pkt_count_q <= pkt_count_q;
      endcase
    end
  end

`ifdef PKT_RX_BUF_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Saturating count of overflow events
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else if (ovf_hit) drop_cnt_q <= sat_inc(drop_cnt_q);
  end

  assign drop_cnt = drop_cnt_q;
`endif

  // The RAM read register is unreset, so data is masked until a word is valid
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_valid_q ? ram_rdata[DATAWIDTH-1:0] : '0;
  assign bus.out_sot   = out_valid_q & first_q;
  assign bus.out_eot   = out_valid_q & ram_rdata[DATAWIDTH];
  assign pkt_count     = pkt_count_q;
  assign overflow      = overflow_q;
  assign proto_err     = proto_err_q;

endmodule
